// File: rtl/proc_pkg.sv
// Shared definitions for the 4-bit processor: instruction fields, opcodes and decoder states.
package proc_pkg;

    localparam int unsigned INSTR_W = 11;

    localparam int unsigned OPC_MSB = 10;
    localparam int unsigned OPC_LSB = 8;
    localparam int unsigned OP1_MSB = 7;
    localparam int unsigned OP1_LSB = 4;
    localparam int unsigned OP2_MSB = 3;
    localparam int unsigned OP2_LSB = 0;

    localparam logic [2:0] OP_STO  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_NOT  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // STO to address 0 is a self-rewrite, so it is harmless to execute.
    localparam logic [INSTR_W-1:0] NOP_WORD = 11'b000_0000_0000;

    localparam logic [1:0] DEC_INIT  = 2'b00;
    localparam logic [1:0] DEC_FETCH = 2'b01;
    localparam logic [1:0] DEC_EXEC  = 2'b10;
    localparam logic [1:0] DEC_STORE = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StRun,
        StStepWait,
        StHalted
    } seq_state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[OPC_MSB:OPC_LSB] == OP_HALT;
    endfunction

endpackage

// File: rtl/prog_store.sv
// Program store: register array, async clear to NOP, sync write, two combinational reads.
module prog_store
    import proc_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [INSTR_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]  rd0_addr_i,
    output logic [INSTR_W-1:0] rd0_data_o,
    input  logic [ADDR_W-1:0]  rd1_addr_i,
    output logic [INSTR_W-1:0] rd1_data_o
);

    logic [INSTR_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= NOP_WORD;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd0_data_o = mem_q[rd0_addr_i];
    assign rd1_data_o = mem_q[rd1_addr_i];

endmodule

// File: rtl/program_sequencer.sv
// Instruction-issue front end: program counter and issue FSM, changing the presented word
// only at the decoder's STORE edge so it stays stable across a full decode cycle.
module program_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned PROG_DEPTH = 16,
    parameter int unsigned PC_W       = 4,
    parameter int unsigned INSTR_W    = 11
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_en_i,
    input  logic [PC_W-1:0]    load_addr_i,
    input  logic [INSTR_W-1:0] load_data_i,
    input  logic               start_i,
    input  logic               step_mode_i,
    input  logic               step_i,
    input  logic [1:0]         dec_state_i,
    output logic [INSTR_W-1:0] instruction_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               running_o,
    output logic               halted_o,
    output logic               retired_o
);

    seq_state_e         state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d, pc_nxt;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [INSTR_W-1:0] rd_cur, rd_nxt;
    logic               retired_q, retired_d;
    logic               step_pend_q, step_pend_d;
    logic               ip, load_ok;

    assign ip      = (dec_state_i == DEC_STORE);
    assign load_ok = load_en_i && ((state_q == StIdle) || (state_q == StHalted));
    assign pc_nxt  = pc_q + PC_W'(1);

    prog_store #(
        .DEPTH  (PROG_DEPTH),
        .ADDR_W (PC_W)
    ) u_store (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en_i    (load_ok),
        .wr_addr_i  (load_addr_i),
        .wr_data_i  (load_data_i),
        .rd0_addr_i (pc_q),
        .rd0_data_o (rd_cur),
        .rd1_addr_i (pc_nxt),
        .rd1_data_o (rd_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            pc_q        <= '0;
            instr_q     <= NOP_WORD;
            retired_q   <= 1'b0;
            step_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            retired_q   <= retired_d;
            step_pend_q <= step_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        retired_d   = 1'b0;
        step_pend_d = step_pend_q;
        unique case (state_q)
            StIdle, StHalted: begin
                // A simultaneous load wins over start.
                if (!load_en_i && start_i) begin
                    state_d = StArm;
                    pc_d    = '0;
                end
            end
            StArm: begin
                if (ip) begin
                    if (is_halt(rd_cur)) begin
                        state_d = StHalted;
                    end else begin
                        instr_d = rd_cur;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (ip) begin
                    retired_d = 1'b1;
                    pc_d      = pc_nxt;
                    if (is_halt(rd_nxt)) begin
                        instr_d = NOP_WORD;
                        state_d = StHalted;
                    end else if (step_mode_i) begin
                        instr_d = NOP_WORD;
                        state_d = StStepWait;
                    end else begin
                        instr_d = rd_nxt;
                    end
                end
            end
            StStepWait: begin
                if (step_i) begin
                    step_pend_d = 1'b1;
                end
                if (ip && (step_pend_q || !step_mode_i)) begin
                    step_pend_d = 1'b0;
                    if (is_halt(rd_cur)) begin
                        state_d = StHalted;
                    end else begin
                        instr_d = rd_cur;
                        state_d = StRun;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        instruction_o = instr_q;
        pc_o          = pc_q;
        retired_o     = retired_q;
        running_o     = (state_q == StArm) || (state_q == StRun) || (state_q == StStepWait);
        halted_o      = (state_q == StHalted);
    end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with a simple cycling decoder-state stimulus.
module tb_program_sequencer;
    import proc_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         load_en;
    logic [3:0]   load_addr;
    logic [10:0]  load_data;
    logic         start;
    logic         step_mode;
    logic         step;
    logic [1:0]   dec_state;
    logic [10:0]  instruction;
    logic [3:0]   pc;
    logic         running;
    logic         halted;
    logic         retired;
    logic         dec_run;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    localparam logic [10:0] W0 = 11'b001_0011_0010;
    localparam logic [10:0] HW = 11'b111_0000_0000;
    localparam logic [10:0] W2 = 11'b010_0001_0001;
    localparam logic [10:0] A0 = 11'b001_0001_0010;
    localparam logic [10:0] A1 = 11'b001_0011_0100;
    localparam logic [10:0] A2 = 11'b001_0101_0110;
    localparam logic [10:0] H3 = 11'b111_1111_1111;

    always #5 clk = ~clk;

    program_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_en_i     (load_en),
        .load_addr_i   (load_addr),
        .load_data_i   (load_data),
        .start_i       (start),
        .step_mode_i   (step_mode),
        .step_i        (step),
        .dec_state_i   (dec_state),
        .instruction_o (instruction),
        .pc_o          (pc),
        .running_o     (running),
        .halted_o      (halted),
        .retired_o     (retired)
    );

    function automatic logic [10:0] wv(input int i);
        logic [3:0] a;
        logic [3:0] b;
        a = i[3:0];
        b = 4'(15 - i);
        return {3'b010, a, b};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (dec_run) dec_state = dec_state + 2'd1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load(input logic [3:0] a, input logic [10:0] d);
        load_en = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; step_mode = 1'b0; step = 1'b0; dec_state = DEC_INIT; dec_run = 1'b0;
        ticks(2);
        check("rst_instr", 16'(instruction), 16'(NOP_WORD));
        check("rst_pc", 16'(pc), 16'h0);
        check("rst_running", 16'(running), 16'h0);
        check("rst_halted", 16'(halted), 16'h0);
        check("rst_retired", 16'(retired), 16'h0);
        reset_n = 1'b1;
        tick();

        // Basic program: one word then HALT; also load+start collision.
        load(4'd0, W0);
        load(4'd1, HW);
        load_en = 1'b1; load_addr = 4'd2; load_data = W2; start = 1'b1;
        tick();
        load_en = 1'b0;
        check("ldstart_idle", 16'(running), 16'h0);
        check("ldstart_write", 16'(dut.u_store.mem_q[2]), 16'(W2));
        tick();
        start = 1'b0;
        check("start_arm", 16'(running), 16'h1);
        check("start_pc", 16'(pc), 16'h0);
        dec_run = 1'b1;
        ticks(3);
        check("arm_nop", 16'(instruction), 16'(NOP_WORD));
        tick();
        check("issue_w0", 16'(instruction), 16'(W0));
        check("issue_pc", 16'(pc), 16'h0);
        ticks(3);
        check("hold_w0", 16'(instruction), 16'(W0));
        check("hold_noret", 16'(retired), 16'h0);
        tick();
        check("halt_state", 16'(halted), 16'h1);
        check("halt_run", 16'(running), 16'h0);
        check("halt_pc", 16'(pc), 16'h1);
        check("halt_instr", 16'(instruction), 16'(NOP_WORD));
        check("halt_ret", 16'(retired), 16'h1);
        tick();
        check("ret_pulse", 16'(retired), 16'h0);

        // Free-run over 16 words with wrap; load and start while running are ignored.
        dec_run = 1'b0; dec_state = DEC_INIT;
        for (int i = 0; i < 16; i++) load(4'(i), wv(i));
        start = 1'b1;
        tick();
        start = 1'b0;
        check("fr_pc0", 16'(pc), 16'h0);
        check("fr_arm", 16'(halted), 16'h0);
        dec_run = 1'b1;
        ticks(4);
        check("fr_first", 16'(instruction), 16'(wv(0)));
        for (int k = 1; k <= 18; k++) begin
            if (k == 5) begin
                load_en = 1'b1; load_addr = 4'd2; load_data = 11'h0; start = 1'b1;
            end
            tick();
            load_en = 1'b0; start = 1'b0;
            check("fr_ret_low", 16'(retired), 16'h0);
            ticks(3);
            check("fr_instr", 16'(instruction), 16'(wv(k % 16)));
            check("fr_pc", 16'(pc), 16'(k % 16));
            check("fr_ret", 16'(retired), 16'h1);
            check("fr_running", 16'(running), 16'h1);
        end

        // Reset during EXECUTE.
        ticks(2);
        reset_n = 1'b0;
        #1;
        check("mrst_instr", 16'(instruction), 16'(NOP_WORD));
        check("mrst_pc", 16'(pc), 16'h0);
        check("mrst_running", 16'(running), 16'h0);
        check("mrst_halted", 16'(halted), 16'h0);
        for (int i = 0; i < 16; i++) check("mrst_mem", 16'(dut.u_store.mem_q[i]), 16'(NOP_WORD));
        dec_run = 1'b0; dec_state = DEC_INIT;
        tick();
        reset_n = 1'b1;
        tick();
        check("mrst_idle", 16'(running), 16'h0);

        // Single-step: ADD, ADD, ADD, HALT.
        load(4'd0, A0);
        load(4'd1, A1);
        load(4'd2, A2);
        load(4'd3, H3);
        step_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        dec_run = 1'b1;
        ticks(4);
        check("st_a0", 16'(instruction), 16'(A0));
        ticks(4);
        check("st_wait_instr", 16'(instruction), 16'(NOP_WORD));
        check("st_wait_pc", 16'(pc), 16'h1);
        check("st_wait_ret", 16'(retired), 16'h1);
        check("st_wait_run", 16'(running), 16'h1);
        ticks(6);
        check("st_hold", 16'(instruction), 16'(NOP_WORD));
        step = 1'b1;
        tick();
        step = 1'b0;
        check("st_pend", 16'(instruction), 16'(NOP_WORD));
        tick();
        check("st_a1", 16'(instruction), 16'(A1));
        check("st_a1_pc", 16'(pc), 16'h1);
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        ticks(2);
        check("st_wait2", 16'(instruction), 16'(NOP_WORD));
        check("st_wait2_pc", 16'(pc), 16'h2);
        ticks(4);
        check("st_no_stray", 16'(instruction), 16'(NOP_WORD));
        step = 1'b1;
        tick();
        step = 1'b0;
        ticks(2);
        check("st_pend2", 16'(instruction), 16'(NOP_WORD));
        tick();
        check("st_a2", 16'(instruction), 16'(A2));
        check("st_a2_pc", 16'(pc), 16'h2);
        ticks(4);
        check("st_halted", 16'(halted), 16'h1);
        check("st_halt_pc", 16'(pc), 16'h3);
        check("st_halt_instr", 16'(instruction), 16'(NOP_WORD));
        step = 1'b1;
        tick();
        step = 1'b0;
        ticks(4);
        check("st_step_ign", 16'(halted), 16'h1);
        check("st_step_ign_pc", 16'(pc), 16'h3);
        check("st_step_ign_run", 16'(running), 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
